// File: rtl/cpu_pkg.sv
// Shared definitions for the front end of the core: default widths,
// reset vector, fetch FSM state type and the NOP encoding used when
// no instruction is being presented to decode.
package cpu_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_INST_W = 32;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

    // All-zero word: decode's sign-extender sees a harmless value when idle
    localparam logic [31:0] INST_NOP = 32'h0000_0000;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fetch_state_t;

    // Clear the byte-offset bits so every fetch address is word aligned
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_queue.sv
// Small circular buffer holding {instruction, pc+4} pairs between the
// instruction memory and decode. A clear wins over push and pop so a
// redirect can discard everything in one cycle.
module ifetch_queue
    import cpu_pkg::*;
#(
    parameter int INST_W = DEF_INST_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              push,
    input  logic [INST_W-1:0] push_inst,
    input  logic [ADDR_W-1:0] push_pc4,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [INST_W-1:0] head_inst,
    output logic [ADDR_W-1:0] head_pc4
);

    localparam int ENTRY_W = INST_W + ADDR_W;
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    logic [ENTRY_W-1:0] slots [DEPTH];
    logic [PTR_W-1:0]   head_ptr;
    logic [PTR_W-1:0]   tail_ptr;
    logic [CNT_W-1:0]   count;
    logic               do_push;
    logic               do_pop;

    // Pushing into a full queue or popping an empty one is silently ignored
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    assign head_inst = slots[head_ptr][ENTRY_W-1 -: INST_W];
    assign head_pc4  = slots[head_ptr][ADDR_W-1:0];

    // Pointer and occupancy bookkeeping; pointers wrap because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (do_push) begin
                tail_ptr <= tail_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                head_ptr <= head_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents only matter while counted as occupied
    always_ff @(posedge clk) begin
        if (!rst && !clear && do_push) begin
            slots[tail_ptr] <= {push_inst, push_pc4};
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, issues one fetch at a time over
// req/ack, queues returned words and presents {inst, pc+4} to decode.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   RUN   | normal fetching; request while the queue has room
//   FLUSH | redirected while a fetch was in flight; hold the old address
//         | until its ack, then drop that word and resume at the new pc
module ifetch_unit
    import cpu_pkg::*;
#(
    parameter int                 ADDR_W   = DEF_ADDR_W,
    parameter int                 INST_W   = DEF_INST_W,
    parameter int                 DEPTH    = 2,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic              clk_i,
    input  logic              rst_i,

    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [INST_W-1:0] imem_data_i,

    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,

    output logic              inst_valid_o,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc4_o,
    input  logic              inst_ready_i
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] old_pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] redirect_target;

    logic              fire;
    logic              q_push;
    logic              q_pop;
    logic              q_clear;
    logic              q_full;
    logic              q_empty;
    logic [INST_W-1:0] q_head_inst;
    logic [ADDR_W-1:0] q_head_pc4;

    logic              unused_redirect_low;

    // Sub-word bits of the redirect target are dropped on purpose
    assign unused_redirect_low = ^redirect_pc_i[1:0];

    assign pc_plus4        = pc + ADDR_W'(4);
    assign redirect_target = {redirect_pc_i[ADDR_W-1:2], 2'b00};

    // Request depends only on registered state, so req/addr cannot change
    // until an ack lets the queue fill or the FSM leave FLUSH
    assign imem_req_o  = !rst_i && ((state == RUN && !q_full) || state == FLUSH);
    assign imem_addr_o = (state == FLUSH) ? old_pc : pc;

    // An ack with no request raised is meaningless and ignored
    assign fire = imem_req_o && imem_ack_i;

    assign q_push  = (state == RUN) && fire && !redirect_i;
    assign q_clear = redirect_i;
    assign q_pop   = inst_valid_o && inst_ready_i;

    assign inst_valid_o = !rst_i && (state == RUN) && !q_empty;
    assign inst_o       = inst_valid_o ? q_head_inst : INST_W'(INST_NOP);
    assign inst_pc4_o   = q_head_pc4;

    ifetch_queue #(
        .INST_W (INST_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_queue (
        .clk       (clk_i),
        .rst       (rst_i),
        .clear     (q_clear),
        .push      (q_push),
        .push_inst (imem_data_i),
        .push_pc4  (pc_plus4),
        .pop       (q_pop),
        .full      (q_full),
        .empty     (q_empty),
        .head_inst (q_head_inst),
        .head_pc4  (q_head_pc4)
    );

    // Fetch FSM: PC advance, redirect capture and in-flight discard tracking
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= RUN;
            pc     <= {RESET_PC[ADDR_W-1:2], 2'b00};
            old_pc <= {RESET_PC[ADDR_W-1:2], 2'b00};
        end else begin
            case (state)
                RUN: begin
                    if (redirect_i) begin
                        pc <= redirect_target;
                        // A pending fetch without ack must still be drained
                        if (imem_req_o && !imem_ack_i) begin
                            old_pc <= pc;
                            state  <= FLUSH;
                        end
                    end else if (q_push) begin
                        pc <= pc_plus4;
                    end
                end
                FLUSH: begin
                    if (redirect_i) begin
                        pc <= redirect_target;
                    end
                    if (imem_ack_i) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a queue-based reference model and
// a variable-latency memory responder.
module tb_ifetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] mem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        ready;

    int n_checks = 0;
    int n_fail   = 0;

    int lat      = 0;
    bit stray    = 0;
    int waited   = 0;

    ifetch_unit #(
        .ADDR_W   (32),
        .INST_W   (32),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .imem_req_o    (req),
        .imem_addr_o   (addr),
        .imem_ack_i    (ack),
        .imem_data_i   (mem_data),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .inst_valid_o  (valid),
        .inst_o        (inst),
        .inst_pc4_o    (pc4),
        .inst_ready_i  (ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A00_0000;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h, required %h", nm, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic wait_valid(input int maxc, input string nm);
        int k;
        k = 0;
        while (!valid && k < maxc) begin
            tick();
            at_neg();
            k++;
        end
        n_checks++;
        if (!valid) begin
            n_fail++;
            $display("FAIL %s: valid still 0 after %0d cycles, required 1", nm, maxc);
        end
    endtask

    // Memory: acks a held request after lat extra cycles; stray injects an unsolicited ack
    initial begin
        ack      = 1'b0;
        mem_data = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            ack = 1'b0;
            if (stray) begin
                ack      = 1'b1;
                mem_data = 32'hBAD0_BAD0;
                waited   = 0;
            end else if (req) begin
                if (waited >= lat) begin
                    ack      = 1'b1;
                    mem_data = mem_word(addr);
                    waited   = 0;
                end else begin
                    waited++;
                end
            end else begin
                waited = 0;
            end
        end
    end

    // Reference model: expected queue contents, pc and pending-discard status
    logic [63:0] m_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_old;
    bit          m_disc = 0;
    bit          m_live = 0;

    always @(posedge clk) begin
        bit req_now;
        if (rst) begin
            m_q.delete();
            m_pc   = RESET_PC;
            m_old  = RESET_PC;
            m_disc = 0;
            m_live = 1;
        end else if (m_live) begin
            req_now = m_disc || (m_q.size() < DEPTH);
            if (m_disc) begin
                if (redirect) m_pc = {redirect_pc[31:2], 2'b00};
                if (ack) m_disc = 0;
            end else if (redirect) begin
                m_q.delete();
                if (req_now && !ack) begin
                    m_disc = 1;
                    m_old  = m_pc;
                end
                m_pc = {redirect_pc[31:2], 2'b00};
            end else begin
                if (m_q.size() != 0 && ready) void'(m_q.pop_front());
                if (req_now && ack) begin
                    m_q.push_back({mem_data, m_pc + 32'd4});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    // Compare DUT against the model every cycle once reset has been seen
    always @(negedge clk) begin
        bit exp_req;
        bit exp_valid;
        if (m_live) begin
            exp_req   = !rst && (m_disc || m_q.size() < DEPTH);
            exp_valid = !rst && !m_disc && m_q.size() != 0;
            check("cmp_req", {31'b0, req}, {31'b0, exp_req});
            if (exp_req) check("cmp_addr", addr, m_disc ? m_old : m_pc);
            check("cmp_valid", {31'b0, valid}, {31'b0, exp_valid});
            if (exp_valid) begin
                check("cmp_inst", inst, m_q[0][63:32]);
                check("cmp_pc4", pc4, m_q[0][31:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        ready       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;

        // Reset, then zero-latency streaming with decode always ready
        tick();
        tick();
        at_neg();
        check("rst_req", {31'b0, req}, 32'd0);
        check("rst_valid", {31'b0, valid}, 32'd0);
        tick();
        rst = 1'b0;
        at_neg();
        check("t1_req", {31'b0, req}, 32'd1);
        check("t1_addr0", addr, 32'h0);
        tick(); at_neg();
        check("t1_inst0", inst, 32'h5A00_0000);
        check("t1_pc4_0", pc4, 32'h4);
        tick(); at_neg();
        check("t1_pc4_1", pc4, 32'h8);
        tick(); at_neg();
        check("t1_pc4_2", pc4, 32'hC);
        check("t1_inst2", inst, 32'h5A00_0008);

        // Backpressure fills the queue, then a one-cycle release
        tick();
        ready = 1'b0;
        rst   = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick(); at_neg();
        check("t2_valid", {31'b0, valid}, 32'd1);
        check("t2_req_low", {31'b0, req}, 32'd0);
        check("t2_pc4_hold", pc4, 32'h4);
        check("t2_inst_hold", inst, 32'h5A00_0000);
        tick();
        stray = 1'b1;
        at_neg();
        check("t2_pc4_stable", pc4, 32'h4);
        tick();
        stray = 1'b0;
        ready = 1'b1;
        at_neg();
        tick();
        ready = 1'b0;
        at_neg();
        check("t2_req_again", {31'b0, req}, 32'd1);
        check("t2_addr8", addr, 32'h8);
        check("t2_pc4_next", pc4, 32'h8);

        // Redirect while full (no fetch pending)
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        at_neg();
        tick();
        redirect = 1'b0;
        at_neg();
        check("t3_valid0", {31'b0, valid}, 32'd0);
        check("t3_addr", addr, 32'h100);
        tick(); at_neg();
        check("t3_pc4", pc4, 32'h104);
        check("t3_inst", inst, 32'h5A00_0100);

        // Ack and redirect together, then redirect during an outstanding fetch
        tick();
        lat   = 3;
        ready = 1'b1;
        rst   = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h10;
        tick();
        redirect = 1'b0;
        at_neg();
        check("t4_addr10", addr, 32'h10);
        check("t4_valid0", {31'b0, valid}, 32'd0);
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        at_neg();
        check("t4_hold_addr", addr, 32'h10);
        check("t4_hold_req", {31'b0, req}, 32'd1);
        tick(); at_neg();
        check("t4_hold_addr2", addr, 32'h10);
        tick(); at_neg();
        check("t4_new_addr", addr, 32'h200);
        check("t4_no_stale", {31'b0, valid}, 32'd0);
        wait_valid(10, "t4_wait");
        check("t4_pc4", pc4, 32'h204);
        check("t4_inst", inst, 32'h5A00_0200);

        // Redirects while in FLUSH: latest wins, including one coinciding with the ack
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h400;
        tick();
        redirect_pc = 32'h500;
        at_neg();
        check("t5_flush_addr", addr, 32'h0);
        tick();
        redirect_pc = 32'h600;
        at_neg();
        check("t5_flush_addr2", addr, 32'h0);
        tick();
        redirect = 1'b0;
        at_neg();
        check("t5_addr600", addr, 32'h600);
        wait_valid(10, "t5_wait");
        check("t5_pc4", pc4, 32'h604);

        // PC wrap at the top of the address space, with unaligned redirect target
        tick();
        lat = 0;
        rst = 1'b1;
        tick();
        rst         = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect = 1'b0;
        at_neg();
        check("t6_addr_top", addr, 32'hFFFF_FFFC);
        tick(); at_neg();
        check("t6_pc4_wrap", pc4, 32'h0);
        check("t6_inst_top", inst, 32'hA5FF_FFFC);
        check("t6_addr_wrap", addr, 32'h0);

        // Reset during an outstanding fetch with an unsolicited ack
        tick();
        lat = 3;
        tick();
        rst   = 1'b1;
        stray = 1'b1;
        at_neg();
        check("t7_rst_req", {31'b0, req}, 32'd0);
        check("t7_rst_valid", {31'b0, valid}, 32'd0);
        tick();
        rst   = 1'b0;
        stray = 1'b0;
        at_neg();
        check("t7_restart_addr", addr, RESET_PC);
        check("t7_restart_valid", {31'b0, valid}, 32'd0);
        wait_valid(10, "t7_wait");
        check("t7_pc4", pc4, 32'h4);
        check("t7_inst", inst, 32'h5A00_0000);

        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch stage directly upstream of decode.
- Keeps the PC and fetches words from a variable-latency instruction memory over a req/ack handshake.
- Buffers fetched words in a small queue and hands {instruction, PC+4} to decode over valid/ready. Decode feeds inst_o[15:0] into the immediate sign-extender.
- Handles branch/jump redirects by flushing the queue and discarding any in-flight fetch.

Parameters:
- ADDR_W, 32, PC and memory address width
- INST_W, 32, instruction word width
- DEPTH, 2, instruction queue entries (power of two, at least 2)
- RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  synchronous active-high reset
- imem_req_o  out  1  fetch request
- imem_addr_o  out  ADDR_W  fetch address; word aligned, [1:0] always 0
- imem_ack_i  in  1  one-cycle acknowledge; imem_data_i valid in the same cycle
- imem_data_i  in  INST_W  fetched instruction
- redirect_i  in  1  one-cycle pulse: branch or jump taken
- redirect_pc_i  in  ADDR_W  new PC; sampled when redirect_i=1
- inst_valid_o  out  1  queue head valid
- inst_o  out  INST_W  queue head instruction
- inst_pc4_o  out  ADDR_W  queue head PC+4
- inst_ready_i  in  1  decode accepts the head this cycle

Behaviour:
- Reset: pc=RESET_PC, count=0, state=RUN, pointers=0. While rst_i=1, imem_req_o=0 and inst_valid_o=0. Reset mid-operation abandons any outstanding fetch. An ack arriving while imem_req_o=0 is ignored.
- States:
  - RUN: normal fetch.
  - FLUSH: a redirect arrived while a fetch is pending; wait for that fetch's ack and discard its data.
- imem_req_o = (state==RUN && count<DEPTH) || state==FLUSH.
  - imem_addr_o = pc in RUN, old_pc in FLUSH.
  - Once raised, req and addr stay stable until ack. This holds because count cannot rise without an ack.
  - At most one fetch is outstanding.
- Push: in RUN, when req && ack && !redirect_i, push {imem_data_i, pc+4} at the tail and set pc <= pc+4. The word is visible on inst_valid_o/inst_o from the next cycle (latency 1 from ack).
- Pop: when inst_valid_o && inst_ready_i, advance the head.
  - Push and pop in the same cycle leave count unchanged.
  - The full queue never pushes, because req is low.
  - Pointers wrap modulo DEPTH.
- Outputs: inst_valid_o = (count!=0). inst_o and inst_pc4_o come from queue registers, so there is no combinational path from memory.
- Redirect in RUN:
  - Queue cleared (count=0) next cycle; any pop in that cycle is dropped.
  - pc <= redirect_pc_i.
  - If req=1 and ack=0: old_pc <= pc and go to FLUSH.
  - If ack=1 in the same cycle: the data is discarded and the state stays RUN.
  - If req=0: stay RUN; the new fetch issues next cycle.
- FLUSH:
  - Nothing is pushed; inst_valid_o=0.
  - On ack: discard the data and go to RUN; the next request uses the redirected pc.
  - A further redirect in FLUSH overwrites pc (latest wins) and stays in FLUSH, or goes to RUN if ack arrives in the same cycle.
- Arithmetic: pc+4 wraps modulo 2^ADDR_W (32'hFFFF_FFFC -> 0), with no error. redirect_pc_i[1:0] is forced to 0.

Decomposition:
- Shared package `cpu_pkg`:
  - ADDR_W, INST_W, RESET_PC defaults
  - `fetch_state_t` enum {RUN, FLUSH}
  - INST_NOP = 32'h0000_0000
- One sub-module, `ifetch_queue`:
  - DEPTH-entry FIFO of {INST_W+ADDR_W} bits
  - ports: push, pop, clear, full, empty, head data
  - clear has priority over push and pop

Test Plan:
- Reset, then zero-latency memory (ack in the cycle after req) with decode always ready. Words at 0x0, 0x4, 0x8 appear on inst_o in consecutive cycles with inst_pc4_o = 0x4, 0x8, 0xC. imem_req_o=0 during reset.
- Backpressure: hold inst_ready_i=0. After 2 acks, inst_valid_o=1, imem_req_o=0 and the head is stable. Release for 1 cycle: the head advances, imem_req_o reasserts the next cycle with addr 0x8.
- Redirect with no fetch pending: queue full, redirect_i=1 with redirect_pc_i=0x100. Next cycle inst_valid_o=0 and imem_addr_o=0x100; the first pushed word has inst_pc4_o=0x104.
- Redirect during an outstanding fetch:
  - Setup: memory latency 3, redirect to 0x200 one cycle after req rises for 0x10.
  - Required: imem_addr_o stays 0x10 until ack; that data never appears on inst_o; the next req carries addr 0x200.
- Simultaneous events: ack and redirect in the same cycle → data dropped, state RUN, next addr = redirect pc. Push and pop in the same cycle with count=1 → count stays 1 and the correct order is kept.
- Edge cases:
  - pc=0xFFFF_FFFC fetch → inst_pc4_o=0x0 and the next addr is 0x0.
  - rst_i asserted while req is outstanding → next cycle req=0 and valid=0; a late ack is ignored; fetch restarts at RESET_PC.
